life_board_engine: RTL and testbench
====================================

Name: life_board_engine

Overview:
- Conway's Game of Life core for a 16x16 board.
- Combines board entry (row-by-row load from switches, row selected by up/down buttons) with generation stepping (one generation per enabled clock).
- Reports per-step birth/death counts and a generation count.
- Sits under the Game of Life top FSM, which drives the mode enables from its SET/ALG/STOP states.

Parameters:
- ROWS, 16, board rows.
- COLS, 16, board columns; cell_inputs width.
- CNT_W, 32, width of the count outputs.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- set_en  input  1  board-entry mode enable.
- alg_en  input  1  generation-stepping enable.
- btn_up  input  1  select previous row (level input; acts on rising edge).
- btn_down  input  1  select next row (level input; acts on rising edge).
- btn_center  input  1  write cell_inputs into the selected row (acts on rising edge).
- cell_inputs  input  COLS  row pattern; bit c = column c.
- board_o  output  ROWS*COLS  current board; cell (r,c) at bit r*COLS+c, 1 = alive.
- row_sel_o  output  4  currently selected row.
- birth_cnt  output  CNT_W  cells born in the last step.
- death_cnt  output  CNT_W  cells that died in the last step.
- generation_cnt  output  CNT_W  steps executed since reset.

Behaviour:
- Reset (async, active-high): board_o=0, row_sel_o=0, all counts 0, button-history registers 0.
- Button edge detection: each button is registered every clock. An event is current=1 and previous=0. A held button produces one event only.
- Mode priority: set_en > alg_en. With both low, everything holds.

Set mode (set_en=1):
- btn_center event: board row row_sel_o (bits r*16+15 .. r*16) <= cell_inputs. Visible on board_o the next cycle.
- btn_down event: row_sel_o+1, wraps 15->0.
- btn_up event: row_sel_o-1, wraps 0->15.
- btn_center has priority. Any up/down event in the same cycle is dropped; the write uses the pre-move row.
- Up and down events in the same cycle: no move.
- Counts do not change.
- Edge-history registers update in every mode. A press while set_en=0 does not act later.

Step mode (alg_en=1, set_en=0), one generation per clock:
- Neighbours: the 8 surrounding cells. Out-of-range cells are dead; no wrap-around.
- Next state of a live cell: alive iff 2 or 3 neighbours.
- Next state of a dead cell: alive iff exactly 3 neighbours.
- Next board is computed combinationally from the current board. On the clock edge: board_o <= next board.
- birth_cnt <= count of cells dead->alive; death_cnt <= count of cells alive->dead. Each is 0..256, zero-extended to CNT_W.
- generation_cnt <= generation_cnt+1, wrapping modulo 2^CNT_W.
- Counts hold their last value whenever no step occurs.
- Empty board steps: board stays 0, counts 0, generation_cnt still increments.

Other rules:
- Reset asserted mid-operation clears everything immediately. The first action after release takes effect on the following edge.
- No unknown values on outputs after reset.

Test Plan:
- Entry: reset; set_en=1; pulse btn_down 3 times; cell_inputs=16'hA5A5; pulse btn_center -> board_o[63:48]=16'hA5A5, all other bits 0, row_sel_o=3.
- Wrap/priority: after reset pulse btn_up -> row_sel_o=15. Then btn_center and btn_down rise together with cell_inputs=16'h0001 -> bit 240 set, row_sel_o stays 15. Holding btn_down 10 cycles -> only one increment.
- Blinker: load row 7 = 16'h01C0 (cols 6-8); alg_en for 1 cycle -> column 7 alive in rows 6-8 (bits 103,119,135 only), birth_cnt=2, death_cnt=2, generation_cnt=1. Second step -> original row back, generation_cnt=2.
- Still life: 2x2 block at rows 0-1, cols 0-1 (bits 0,1,16,17); step 5 times -> board unchanged, birth_cnt=0, death_cnt=0, generation_cnt=5.
- Edge/no-wrap: single cell at bit 255 plus cells at bits 0 and 15; step -> board_o=0, death_cnt=3, birth_cnt=0. Confirms no torus neighbours.
- Reset mid-run: run the blinker 3 steps, assert reset asynchronously between edges -> board_o, counts and row_sel_o are 0 before the next clock edge.

Source files
------------

// File: rtl/life_board_engine.sv
// 16x16 Game of Life core: row-wise board entry and
// per-clock generation stepping with birth/death stats.
module life_board_engine #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 set_en,
  input  logic                 alg_en,
  input  logic                 btn_up,
  input  logic                 btn_down,
  input  logic                 btn_center,
  input  logic [COLS-1:0]      cell_inputs,
  output logic [ROWS*COLS-1:0] board_o,
  output logic [3:0]           row_sel_o,
  output logic [CNT_W-1:0]     birth_cnt,
  output logic [CNT_W-1:0]     death_cnt,
  output logic [CNT_W-1:0]     generation_cnt
);

  localparam int N = ROWS * COLS;

  logic                       up_q;
  logic                       down_q;
  logic                       ctr_q;
  logic                       up_ev;
  logic                       down_ev;
  logic                       ctr_ev;
  logic [3:0]                 row_inc;
  logic [3:0]                 row_dec;
  logic [N-1:0]               entry_board;
  logic [N-1:0]               next_board;
  logic [N-1:0]               born;
  logic [N-1:0]               died;
  logic [CNT_W-1:0]           births;
  logic [CNT_W-1:0]           deaths;
  logic [ROWS+1:0][COLS+1:0]  pad;

  assign up_ev   = btn_up & ~up_q;
  assign down_ev = btn_down & ~down_q;
  assign ctr_ev  = btn_center & ~ctr_q;

  // Row selector wraps at both ends of the board.
  always_comb begin
    row_inc = row_sel_o + 4'd1;
    row_dec = row_sel_o - 4'd1;
    if (row_sel_o == 4'(ROWS - 1))
      row_inc = 4'd0;
    if (row_sel_o == 4'd0)
      row_dec = 4'(ROWS - 1);
  end

  // Board with the selected row replaced by the switches.
  for (genvar r = 0; r < ROWS; r++) begin : g_entry
    assign entry_board[r*COLS +: COLS] =
      (row_sel_o == 4'(r)) ? cell_inputs
                           : board_o[r*COLS +: COLS];
  end

  // Dead ring around the board: edges see no neighbours.
  for (genvar r = 0; r < ROWS + 2; r++) begin : g_pr
    for (genvar c = 0; c < COLS + 2; c++) begin : g_pc
      if (r == 0 || r == ROWS + 1 ||
          c == 0 || c == COLS + 1) begin : g_edge
        assign pad[r][c] = 1'b0;
      end else begin : g_in
        assign pad[r][c] = board_o[(r-1)*COLS + c - 1];
      end
    end
  end

  // Per-cell neighbour count and Life rule.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [3:0] n;
      logic       cur;
      assign n = 4'(pad[r][c])     + 4'(pad[r][c+1])
               + 4'(pad[r][c+2])   + 4'(pad[r+1][c])
               + 4'(pad[r+1][c+2]) + 4'(pad[r+2][c])
               + 4'(pad[r+2][c+1]) + 4'(pad[r+2][c+2]);
      assign cur = board_o[r*COLS + c];
      assign next_board[r*COLS + c] =
        (n == 4'd3) | (cur & (n == 4'd2));
    end
  end

  assign born   = ~board_o & next_board;
  assign died   = board_o & ~next_board;
  assign births = CNT_W'($countones(born));
  assign deaths = CNT_W'($countones(died));

  // Button history, updated in every mode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      up_q   <= 1'b0;
      down_q <= 1'b0;
      ctr_q  <= 1'b0;
    end else begin
      up_q   <= btn_up;
      down_q <= btn_down;
      ctr_q  <= btn_center;
    end
  end

  // Board, row select and statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      board_o        <= '0;
      row_sel_o      <= '0;
      birth_cnt      <= '0;
      death_cnt      <= '0;
      generation_cnt <= '0;
    end else if (set_en) begin
      if (ctr_ev)
        board_o <= entry_board;
      else if (down_ev & ~up_ev)
        row_sel_o <= row_inc;
      else if (up_ev & ~down_ev)
        row_sel_o <= row_dec;
    end else if (alg_en) begin
      board_o        <= next_board;
      birth_cnt      <= births;
      death_cnt      <= deaths;
      generation_cnt <= generation_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_life_board_engine.sv
// Bench for life_board_engine: reference Life model
// feeding a scoreboard, plus fixed-pattern checks.
module tb_life_board_engine;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         set_en = 1'b0;
  logic         alg_en = 1'b0;
  logic         btn_up = 1'b0;
  logic         btn_down = 1'b0;
  logic         btn_center = 1'b0;
  logic [15:0]  cell_inputs = '0;
  logic [255:0] board_o;
  logic [3:0]   row_sel_o;
  logic [31:0]  birth_cnt;
  logic [31:0]  death_cnt;
  logic [31:0]  generation_cnt;

  life_board_engine dut (
    .clk(clk),
    .reset(reset),
    .set_en(set_en),
    .alg_en(alg_en),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .btn_center(btn_center),
    .cell_inputs(cell_inputs),
    .board_o(board_o),
    .row_sel_o(row_sel_o),
    .birth_cnt(birth_cnt),
    .death_cnt(death_cnt),
    .generation_cnt(generation_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] board;
    logic [3:0]   row;
    logic [31:0]  birth;
    logic [31:0]  death;
    logic [31:0]  gen;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  logic [255:0] m_board;
  logic [3:0]   m_row;
  int           m_birth;
  int           m_death;
  logic [31:0]  m_gen;
  bit           p_up, p_down, p_ctr;
  logic [255:0] t;

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] life(
    input logic [255:0] b, output int nb, output int nd);
    bit g[18][18];
    logic [255:0] q;
    int n;
    bit a, x;
    q = '0;
    nb = 0;
    nd = 0;
    for (int r = 0; r < 18; r++)
      for (int c = 0; c < 18; c++)
        g[r][c] = 1'b0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        g[r+1][c+1] = b[r*16+c];
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        n = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            if (!(i == 1 && j == 1))
              n += int'(g[r+i][c+j]);
        a = b[r*16+c];
        x = (n == 3) || (a && n == 2);
        q[r*16+c] = x;
        if (x && !a) nb++;
        if (!x && a) nd++;
      end
    return q;
  endfunction

  task automatic model_reset();
    m_board = '0;
    m_row = '0;
    m_birth = 0;
    m_death = 0;
    m_gen = '0;
    p_up = 0;
    p_down = 0;
    p_ctr = 0;
  endtask

  task automatic cyc(input bit s, input bit a,
                     input bit u, input bit d,
                     input bit ctr,
                     input logic [15:0] cells);
    exp_t e;
    bit eu, ed, ec;
    int nb, nd;
    set_en = s;
    alg_en = a;
    btn_up = u;
    btn_down = d;
    btn_center = ctr;
    cell_inputs = cells;
    eu = u && !p_up;
    ed = d && !p_down;
    ec = ctr && !p_ctr;
    if (s) begin
      if (ec)
        m_board[int'(m_row)*16 +: 16] = cells;
      else if (ed && !eu)
        m_row = m_row + 4'd1;
      else if (eu && !ed)
        m_row = m_row - 4'd1;
    end else if (a) begin
      m_board = life(m_board, nb, nd);
      m_birth = nb;
      m_death = nd;
      m_gen = m_gen + 32'd1;
    end
    p_up = u;
    p_down = d;
    p_ctr = ctr;
    e.board = m_board;
    e.row = m_row;
    e.birth = 32'(m_birth);
    e.death = 32'(m_death);
    e.gen = m_gen;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("board", board_o, e.board);
    chk("row", 256'(row_sel_o), 256'(e.row));
    chk("birth", 256'(birth_cnt), 256'(e.birth));
    chk("death", 256'(death_cnt), 256'(e.death));
    chk("gen", 256'(generation_cnt), 256'(e.gen));
  endtask

  task automatic press(input bit u, input bit d,
                       input bit ctr,
                       input logic [15:0] cells);
    cyc(1, 0, u, d, ctr, cells);
    cyc(1, 0, 0, 0, 0, cells);
  endtask

  task automatic step(input int n);
    repeat (n) cyc(0, 1, 0, 0, 0, '0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_board"}, board_o, '0);
    chk({tag, "_row"}, 256'(row_sel_o), '0);
    chk({tag, "_birth"}, 256'(birth_cnt), '0);
    chk({tag, "_death"}, 256'(death_cnt), '0);
    chk({tag, "_gen"}, 256'(generation_cnt), '0);
  endtask

  task automatic do_reset();
    set_en = 0;
    alg_en = 0;
    btn_up = 0;
    btn_down = 0;
    btn_center = 0;
    cell_inputs = '0;
    reset = 1;
    model_reset();
    #1;
    chk_zero("rst");
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  initial begin
    #2;
    do_reset();

    // Entry: row 3 <= A5A5
    repeat (3) press(0, 1, 0, '0);
    press(0, 0, 1, 16'hA5A5);
    t = '0;
    t[63:48] = 16'hA5A5;
    chk("entry_board", board_o, t);
    chk("entry_row", 256'(row_sel_o), 256'd3);

    // Wrap, center priority, held button
    do_reset();
    press(1, 0, 0, '0);
    chk("wrap_up", 256'(row_sel_o), 256'd15);
    press(0, 1, 1, 16'h0001);
    t = '0;
    t[240] = 1'b1;
    chk("prio_board", board_o, t);
    chk("prio_row", 256'(row_sel_o), 256'd15);
    repeat (10) cyc(1, 0, 0, 1, 0, '0);
    cyc(1, 0, 0, 0, 0, '0);
    chk("hold_row", 256'(row_sel_o), 256'd0);
    cyc(1, 0, 1, 1, 0, '0);
    cyc(1, 0, 0, 0, 0, '0);
    chk("updown_row", 256'(row_sel_o), 256'd0);
    cyc(0, 0, 0, 1, 0, '0);
    cyc(1, 0, 0, 1, 0, '0);
    cyc(1, 0, 0, 0, 0, '0);
    chk("late_row", 256'(row_sel_o), 256'd0);

    // Blinker
    do_reset();
    repeat (7) press(0, 1, 0, '0);
    press(0, 0, 1, 16'h01C0);
    step(1);
    t = '0;
    t[103] = 1'b1;
    t[119] = 1'b1;
    t[135] = 1'b1;
    chk("blk1_board", board_o, t);
    chk("blk1_birth", 256'(birth_cnt), 256'd2);
    chk("blk1_death", 256'(death_cnt), 256'd2);
    chk("blk1_gen", 256'(generation_cnt), 256'd1);
    step(1);
    t = '0;
    t[127:112] = 16'h01C0;
    chk("blk2_board", board_o, t);
    chk("blk2_gen", 256'(generation_cnt), 256'd2);
    cyc(0, 0, 0, 0, 0, '0);
    chk("hold_birth", 256'(birth_cnt), 256'd2);

    // Still-life block
    do_reset();
    press(0, 0, 1, 16'h0003);
    press(0, 1, 0, '0);
    press(0, 0, 1, 16'h0003);
    step(5);
    t = '0;
    t[0] = 1'b1;
    t[1] = 1'b1;
    t[16] = 1'b1;
    t[17] = 1'b1;
    chk("blk_board", board_o, t);
    chk("blk_birth", 256'(birth_cnt), 256'd0);
    chk("blk_death", 256'(death_cnt), 256'd0);
    chk("blk_gen", 256'(generation_cnt), 256'd5);

    // Corners, no torus wrap
    do_reset();
    press(0, 0, 1, 16'h8001);
    press(1, 0, 0, '0);
    press(0, 0, 1, 16'h8000);
    step(1);
    chk("edge_board", board_o, '0);
    chk("edge_death", 256'(death_cnt), 256'd3);
    chk("edge_birth", 256'(birth_cnt), 256'd0);
    step(1);
    chk("empty_gen", 256'(generation_cnt), 256'd2);
    chk("empty_death", 256'(death_cnt), 256'd0);

    // Async reset mid-run
    do_reset();
    repeat (7) press(0, 1, 0, '0);
    press(0, 0, 1, 16'h01C0);
    step(3);
    @(negedge clk);
    reset = 1;
    model_reset();
    #1;
    chk_zero("mid");
    @(posedge clk);
    #1;
    reset = 0;
    press(0, 1, 0, '0);
    chk("post_row", 256'(row_sel_o), 256'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
